// File: rtl/imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : imem_boot_loader                                                  |
// | Streams a byte-wide program image into instruction memory as little-endian |
// | 32-bit words and holds the CPU in reset until the whole image is written.  |
// | Optional feature macro: BOOT_CHECKSUM_EN (final byte is a mod-256 sum).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module imem_boot_loader #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_ERROR   = 2'd3;

  localparam logic [ADDR_W:0] c_FULL_COUNT = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] c_ONE        = (ADDR_W+1)'(1);

  logic [1:0]      state_q, state_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [31:0]     word_q, word_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            last_q, last_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic            chk_ok_q, chk_ok_d;
`endif

  logic        w_full;
  logic        w_accept;
  logic [31:0] w_merged;

  // Memory is full once every word slot has been written; any further byte is an overflow.
  assign w_full   = (count_q == c_FULL_COUNT);
  assign w_accept = s_valid && s_ready;

  // Drop the incoming byte into its little-endian lane of the word being assembled.
  always_comb begin
    w_merged = word_q;
    case (byte_idx_q)
      2'd0:    w_merged[7:0]   = s_data;
      2'd1:    w_merged[15:8]  = s_data;
      2'd2:    w_merged[23:16] = s_data;
      default: w_merged[31:24] = s_data;
    endcase
  end

  // Next-state logic for the collect / write / release / error sequence.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    count_d    = count_q;
    last_d     = last_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
    chk_ok_d   = chk_ok_q;
`endif
    case (state_q)
      S_COLLECT: begin
        if (s_valid && w_full) begin
          // Overflow is detected before any write could run past the last word.
          state_d = S_ERROR;
        end else if (w_accept) begin
`ifdef BOOT_CHECKSUM_EN
          if (s_last) begin
            // Checksum byte: compared, never stored.
            last_d   = 1'b1;
            chk_ok_d = (sum_q == s_data);
            if (byte_idx_q == 2'd0) begin
              state_d = (sum_q == s_data) ? S_RELEASE : S_ERROR;
            end else begin
              state_d = S_WRITE;
            end
          end else begin
            word_d     = w_merged;
            sum_d      = sum_q + s_data;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              state_d = S_WRITE;
            end
          end
`else
          word_d     = w_merged;
          byte_idx_d = byte_idx_q + 2'd1;
          if (s_last) begin
            last_d = 1'b1;
          end
          if ((byte_idx_q == 2'd3) || s_last) begin
            state_d = S_WRITE;
          end
`endif
        end
      end
      S_WRITE: begin
        count_d    = count_q + c_ONE;
        byte_idx_d = 2'd0;
        word_d     = 32'd0;
        if (last_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = chk_ok_q ? S_RELEASE : S_ERROR;
`else
          state_d = S_RELEASE;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State registers with synchronous reset back to an empty, CPU-held load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_COLLECT;
      byte_idx_q <= 2'd0;
      word_q     <= 32'd0;
      count_q    <= '0;
      last_q     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= 8'd0;
      chk_ok_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      count_q    <= count_d;
      last_q     <= last_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
      chk_ok_q   <= chk_ok_d;
`endif
    end
  end

  // Outputs decode directly from state so the write pulse and release line up with it.
  assign s_ready    = (state_q == S_COLLECT) && !w_full;
  assign imem_we    = (state_q == S_WRITE);
  assign imem_waddr = count_q[ADDR_W-1:0];
  assign imem_wdata = word_q;
  assign cpu_rst_n  = (state_q == S_RELEASE);
  assign done       = (state_q == S_RELEASE);
  assign err        = (state_q == S_ERROR);
  assign word_count = count_q;

endmodule
`default_nettype wire
